// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is illegal)
//   - FSM state enumeration
//   - is_misaligned(): flags illegal sizes and misaligned addresses
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // An access is rejected when its size code is illegal or its byte offset
  // is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational byte-lane logic for the load/store unit (little-endian).
//   word        in  32  word read from RAM
//   wdata       in  32  right-justified store data
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size code
//   is_unsigned in  1   zero-extend (1) or sign-extend (0) sub-word loads
//   load_data   out 32  selected lane, extended to 32 bits
//   store_data  out 32  word with the target lane replaced by wdata
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = word[{offset[1], 4'b0000} +: 16];
    load_data  = word;
    store_data = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        // Word access: load passes through, store replaces the whole word.
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage front end to the word-addressed data RAM.
// One request in flight; sub-word stores are read-modify-write.
//   clk, reset       single clock, synchronous active-high reset
//   req_*            request handshake (valid/ready) and payload
//   resp_valid       one-cycle response pulse per accepted request
//   resp_rdata       extended load data (0 for stores and errors)
//   resp_error       misaligned address or illegal size
//   mem_address      word-aligned byte address to RAM
//   mem_read_en      RAM read strobe, data returns combinationally
//   mem_write_en     RAM write strobe
//   mem_data_write   full word written to RAM
//   mem_data_in      RAM read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  lsu_state_t            state_q, state_d;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  unsigned_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;
  logic [ADDR_WIDTH-1:0] word_address;
  logic                  accept;

  assign accept       = req_valid && (state_q == ST_IDLE);
  assign word_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_lane_unit u_lane (
    .word        (word_q),
    .wdata       (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) error_q <= is_misaligned(req_size, req_addr[1:0]);
    end
  end

  // NOTE: payload and word registers carry no reset; they are only read in
  // states reachable after they have been loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= req_addr;
      size_q     <= req_size;
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      wdata_q    <= req_wdata;
    end
    if (state_q == ST_READ) word_q <= mem_data_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) state_d = ST_RESP;
          else if (req_write && req_size == SZ_WORD)  state_d = ST_WRITE;
          else                                        state_d = ST_READ;
        end
      end
      ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_error     = 1'b0;
    resp_rdata     = '0;
    mem_address    = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_data_write = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_READ: begin
        mem_read_en = 1'b1;
        mem_address = word_address;
      end
      ST_WRITE: begin
        mem_write_en   = 1'b1;
        mem_address    = word_address;
        mem_data_write = store_data;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_error = error_q;
        if (!error_q && !write_q) resp_rdata = load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_write, mem_data_in;
  logic        mem_read_en, mem_write_en;

  int checks = 0;
  int fails  = 0;
  int n_reads = 0, n_writes = 0, n_resps = 0;

  logic [31:0] ram [0:63];
  logic        preload_en = 1'b0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_data_write (mem_data_write),
    .mem_data_in    (mem_data_in)
  );

  // Behavioural RAM: combinational read, write on the rising edge.
  assign mem_data_in = ram[mem_address[7:2]];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4] <= 32'h8070F0A5;
    end else if (mem_write_en) begin
      ram[mem_address[7:2]] <= mem_data_write;
    end
    if (mem_read_en)  n_reads  <= n_reads + 1;
    if (mem_write_en) n_writes <= n_writes + 1;
    if (resp_valid)   n_resps  <= n_resps + 1;
  end

  task automatic preload();
    @(negedge clk) preload_en = 1'b1;
    @(negedge clk) preload_en = 1'b0;
  endtask

  // Presents a request for one edge (T) and returns at the negedge of the
  // cycle after T with req_valid dropped.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_read_en, mem_write_en} !== 5'b10000 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_write !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, want ready=1 all others 0",
               req_ready, resp_valid, resp_error, mem_read_en, mem_write_en, resp_rdata, mem_address, mem_data_write);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b rv=%b rd=%b, want 1 0 0", req_ready, resp_valid, mem_read_en);
    end
  endtask

  typedef struct packed {
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] exp;
  } load_vec_t;

  task automatic test_loads();
    load_vec_t v [7];
    int w0;
    v[0] = '{SZ_BYTE, 1'b0, 32'h10, 32'hFFFFFFA5};
    v[1] = '{SZ_BYTE, 1'b1, 32'h13, 32'h00000080};
    v[2] = '{SZ_BYTE, 1'b0, 32'h12, 32'h00000070};
    v[3] = '{SZ_HALF, 1'b0, 32'h12, 32'hFFFF8070};
    v[4] = '{SZ_HALF, 1'b1, 32'h10, 32'h0000F0A5};
    v[5] = '{SZ_HALF, 1'b0, 32'h10, 32'hFFFFF0A5};
    v[6] = '{SZ_WORD, 1'b0, 32'h10, 32'h8070F0A5};
    for (int i = 0; i < 7; i++) begin
      preload();
      w0 = n_writes;
      issue(1'b0, v[i].sz, v[i].uns, v[i].addr, 32'hFFFFFFFF);
      checks++;
      if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || req_ready !== 1'b0 ||
          mem_address !== {v[i].addr[31:2], 2'b00} || resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL load[%0d]_read: rd=%b wr=%b ready=%b addr=%h rv=%b, want 1 0 0 %h 0",
                 i, mem_read_en, mem_write_en, req_ready, mem_address, resp_valid, {v[i].addr[31:2], 2'b00});
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== v[i].exp || resp_error !== 1'b0 || mem_read_en !== 1'b0) begin
        fails++;
        $display("FAIL load[%0d]_resp: rv=%b rdata=%h err=%b rd=%b, want 1 %h 0 0",
                 i, resp_valid, resp_rdata, resp_error, mem_read_en, v[i].exp);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || n_writes != w0) begin
        fails++;
        $display("FAIL load[%0d]_done: rv=%b ready=%b writes=%0d, want 0 1 %0d",
                 i, resp_valid, req_ready, n_writes, w0);
      end
    end
  endtask

  typedef struct packed {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } store_vec_t;

  task automatic test_subword_store();
    store_vec_t v [4];
    v[0] = '{SZ_BYTE, 32'h11, 32'h000000CC, 32'h8070CCA5};
    v[1] = '{SZ_HALF, 32'h12, 32'h00001234, 32'h1234F0A5};
    v[2] = '{SZ_BYTE, 32'h13, 32'hFFFFFF11, 32'h1170F0A5};
    v[3] = '{SZ_HALF, 32'h10, 32'hABCD5678, 32'h80705678};
    for (int i = 0; i < 4; i++) begin
      preload();
      issue(1'b1, v[i].sz, 1'b0, v[i].addr, v[i].wd);
      checks++;
      if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_address !== 32'h10 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL store[%0d]_read: rd=%b wr=%b addr=%h ready=%b, want 1 0 00000010 0",
                 i, mem_read_en, mem_write_en, mem_address, req_ready);
      end
      @(negedge clk);
      checks++;
      if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_address !== 32'h10 ||
          mem_data_write !== v[i].exp || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL store[%0d]_write: wr=%b rd=%b addr=%h data=%h ready=%b rv=%b, want 1 0 00000010 %h 0 0",
                 i, mem_write_en, mem_read_en, mem_address, mem_data_write, req_ready, resp_valid, v[i].exp);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0 ||
          req_ready !== 1'b0 || mem_write_en !== 1'b0) begin
        fails++;
        $display("FAIL store[%0d]_resp: rv=%b rdata=%h err=%b ready=%b wr=%b, want 1 0 0 0 0",
                 i, resp_valid, resp_rdata, resp_error, req_ready, mem_write_en);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ram[4] !== v[i].exp) begin
        fails++;
        $display("FAIL store[%0d]_ram: ready=%b rv=%b ram=%h, want 1 0 %h",
                 i, req_ready, resp_valid, ram[4], v[i].exp);
      end
    end
  endtask

  task automatic test_word_store();
    int r0;
    preload();
    r0 = n_reads;
    issue(1'b1, SZ_WORD, 1'b1, 32'h14, 32'hDEADBEEF);
    checks++;
    if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_address !== 32'h14 ||
        mem_data_write !== 32'hDEADBEEF || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL sw_write: wr=%b rd=%b addr=%h data=%h ready=%b, want 1 0 00000014 deadbeef 0",
               mem_write_en, mem_read_en, mem_address, mem_data_write, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0 || mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL sw_resp: rv=%b rdata=%h err=%b wr=%b, want 1 0 0 0",
               resp_valid, resp_rdata, resp_error, mem_write_en);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || ram[5] !== 32'hDEADBEEF || ram[4] !== 32'h8070F0A5 || n_reads != r0) begin
      fails++;
      $display("FAIL sw_ram: ready=%b ram5=%h ram4=%h reads=%0d, want 1 deadbeef 8070f0a5 %0d",
               req_ready, ram[5], ram[4], n_reads, r0);
    end
  endtask

  task automatic test_errors();
    logic        w   [5];
    logic [1:0]  sz  [5];
    logic [31:0] a   [5];
    int r0, w0;
    w[0] = 1'b1; sz[0] = SZ_WORD; a[0] = 32'h12;
    w[1] = 1'b0; sz[1] = SZ_HALF; a[1] = 32'h11;
    w[2] = 1'b0; sz[2] = 2'b11;   a[2] = 32'h10;
    w[3] = 1'b0; sz[3] = SZ_WORD; a[3] = 32'h12;
    w[4] = 1'b1; sz[4] = SZ_HALF; a[4] = 32'h13;
    preload();
    for (int i = 0; i < 5; i++) begin
      r0 = n_reads; w0 = n_writes;
      issue(w[i], sz[i], 1'b0, a[i], 32'h5A5A5A5A);
      checks++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0 ||
          mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL err[%0d]_resp: rv=%b err=%b rdata=%h rd=%b wr=%b ready=%b, want 1 1 0 0 0 0",
                 i, resp_valid, resp_error, resp_rdata, mem_read_en, mem_write_en, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || n_reads != r0 || n_writes != w0) begin
        fails++;
        $display("FAIL err[%0d]_done: ready=%b rv=%b reads=%0d writes=%0d, want 1 0 %0d %0d",
                 i, req_ready, resp_valid, n_reads, n_writes, r0, w0);
      end
    end
    checks++;
    if (ram[4] !== 32'h8070F0A5) begin
      fails++;
      $display("FAIL err_ram: ram=%h, want 8070f0a5", ram[4]);
    end
  endtask

  task automatic test_reset_abort();
    int w0, s0;
    preload();
    w0 = n_writes; s0 = n_resps;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000055);
    checks++;
    if (mem_read_en !== 1'b1) begin
      fails++;
      $display("FAIL abort_read: rd=%b, want 1", mem_read_en);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: ready=%b wr=%b rd=%b rv=%b, want 1 0 0 0",
               req_ready, mem_write_en, mem_read_en, resp_valid);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (n_writes != w0 || n_resps != s0 || ram[4] !== 32'h8070F0A5 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_effects: writes=%0d resps=%0d ram=%h ready=%b, want %0d %0d 8070f0a5 1",
               n_writes, n_resps, ram[4], req_ready, w0, s0);
    end
  endtask

  task automatic test_back_to_back();
    int w0, s0;
    preload();
    w0 = n_writes; s0 = n_resps;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clk);
    // lw accepted; the requester now holds the next request (sw 0x14).
    req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    checks++;
    if (req_ready !== 1'b0 || mem_read_en !== 1'b1 || mem_address !== 32'h10) begin
      fails++;
      $display("FAIL b2b_read: ready=%b rd=%b addr=%h, want 0 1 00000010", req_ready, mem_read_en, mem_address);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h8070F0A5 || mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_resp1: ready=%b rv=%b rdata=%h wr=%b, want 0 1 8070f0a5 0",
               req_ready, resp_valid, resp_rdata, mem_write_en);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: ready=%b rv=%b wr=%b, want 1 0 0", req_ready, resp_valid, mem_write_en);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_write_en !== 1'b1 || mem_address !== 32'h14 || mem_data_write !== 32'hCAFEF00D || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_write: wr=%b addr=%h data=%h ready=%b, want 1 00000014 cafef00d 0",
               mem_write_en, mem_address, mem_data_write, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL b2b_resp2: rv=%b err=%b rdata=%h, want 1 0 0", resp_valid, resp_error, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if (ram[5] !== 32'hCAFEF00D || n_writes != w0 + 1 || n_resps != s0 + 2 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_totals: ram5=%h writes=%0d resps=%0d ready=%b, want cafef00d %0d %0d 1",
               ram[5], n_writes, n_resps, req_ready, w0 + 1, s0 + 2);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_subword_store();
    test_word_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side front end to the word-addressed data RAM in the MIPS datapath. Accepts one load/store request at a time from the MEM stage and converts byte, halfword and word accesses into 32-bit word reads and writes on the RAM port. Performs lane selection, sign or zero extension, and read-modify-write merging for sub-word stores. Misaligned accesses are flagged and never reach memory.

## Interface
- DATA_WIDTH, 32: RAM word width; fixed at 32, 4 byte lanes.
- ADDR_WIDTH, 32: byte address width.

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid; misaligned or illegal size
- mem_address  out  32  byte address, always word-aligned ({addr[31:2],2'b00})
- mem_read_en  out  1  RAM read strobe
- mem_write_en  out  1  RAM write strobe
- mem_data_write  out  32  full word to RAM
- mem_data_in  in  32  RAM read data, valid combinationally in the cycle mem_read_en is high

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On transfer, latch addr/size/write/unsigned/wdata.
  - Illegal size, half with addr[0]=1, or word with addr[1:0]≠0 -> RESP with error; no mem strobe.
  - Load or sub-word store -> READ. Word store -> WRITE.
- READ: mem_read_en=1. mem_data_in captured into word register at cycle end. Load -> RESP. Sub-word store -> WRITE.
- WRITE: mem_write_en=1. Word store drives wdata. Sub-word store drives captured word with target lane replaced. Then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Lanes are little-endian. Byte lane = addr[1:0], bits [8k+7:8k]. Half lane = addr[1], bits [16h+15:16h].
- Load extension: byte/half is sign-extended from its MSB unless unsigned. Word passes through. req_unsigned is ignored for word loads and for stores.
- Unused mem outputs are 0 whenever their strobe is low.
- No pipelining: at most one request in flight.

## Timing
- Accept at edge T (end of IDLE cycle):
  - error: resp at T+1.
  - word store: write at T+1, resp at T+2.
  - load: read at T+1, resp at T+2.
  - sub-word store: read at T+1, write at T+2, resp at T+3.
- Reset values, after the reset edge: state IDLE; req_ready=1; all other outputs 0.
- reset takes priority in any state:
  - The next cycle is IDLE with no strobe.
  - An aborted sub-word store issues no write.
  - No resp is produced for the aborted request.
- req_valid in non-IDLE states is ignored. The requester holds the request until req_ready.
- Maximum throughput: one load per 3 cycles.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - the misalignment check function.
- Sub-module lsu_lane_unit is purely combinational and provides:
  - load extract/extend from word + addr[1:0] + size + unsigned;
  - store merge of old word + wdata + addr[1:0] + size.
- The top level holds the FSM and the request/word registers.

## Test plan
Preload RAM word 0x10 = 0x8070F0A5 before each scenario.
- lb 0x10 signed -> resp_rdata 0xFFFFFFA5 at T+2. lbu 0x13 -> 0x00000080.
- lh 0x12 signed -> 0xFFFF8070. lhu 0x10 -> 0x0000F0A5. lw 0x10 -> 0x8070F0A5.
- sb 0x11, wdata 0x000000CC -> one read at T+1, write 0x8070CCA5 at T+2, resp at T+3, req_ready low T+1..T+3. sh 0x12, wdata 0x1234 -> write 0x1234F0A5.
- sw 0x12 -> resp_error=1, rdata 0 at T+1, no mem strobe. lh 0x11 and size 11 -> same.
- sb 0x10 with reset asserted in READ -> no mem_write_en, RAM unchanged, no resp_valid, req_ready=1 the cycle after reset.
- req_valid held across lw 0x10 then sw 0x14 -> second accepted only after first resp, sw strobe at correct address, ready deasserted between.
